// File: rtl/flex_fifo_pkg.sv
// Elaboration-time helpers for flex_fifo parameter legality checks.
package flex_fifo_pkg;

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

    function automatic bit thresh_ok(input int t, input int depth);
        return (t >= 0) && (t <= depth);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write, read port either registered
// (enable-gated, resettable output register) or combinational.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter bit REG_READ   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    if (REG_READ) begin : g_reg_read
        logic [DATA_WIDTH-1:0] rd_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_q <= '0;
            end else if (rd_en) begin
                rd_q <= mem[rd_addr];
            end
        end

        assign rd_data = rd_q;
    end else begin : g_comb_read
        // Output is forced to zero when not enabled so an idle port reads 0.
        assign rd_data = (rd_en && rst_n) ? mem[rd_addr] : '0;
    end

endmodule

// File: rtl/util.vh
// Shared helper macros for the FIFO codebase.
`ifndef UTIL_VH
`define UTIL_VH
`define LOG2(x) $clog2(x)
`endif

// File: rtl/flex_fifo.sv
// Synchronous FIFO with standard or first-word-fall-through read, threshold
// flags and sticky overflow/underflow errors.
`include "util.vh"

module flex_fifo
  import flex_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 32,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int ADDR_WIDTH    = `LOG2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

  if (!is_pow2(FIFO_DEPTH)) begin : g_bad_depth
    $error("flex_fifo: FIFO_DEPTH must be a power of two >= 2");
  end
  if (!thresh_ok(AFULL_THRESH, FIFO_DEPTH) || !thresh_ok(AEMPTY_THRESH, FIFO_DEPTH)) begin : g_bad_thresh
    $error("flex_fifo: thresholds must lie within 0..FIFO_DEPTH");
  end

  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic                rd_acc;
  logic                wr_acc;
  logic                mem_rd_en;

  // The extra pointer MSB distinguishes full from empty, so occupancy is
  // simply the modulo-2*DEPTH pointer difference.
  assign count        = wr_ptr - rd_ptr;
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);

  // Handshake: a write is taken when wr_en is high and the FIFO is not full
  // or a read is taken in the same cycle; a read is taken only when rd_en is
  // high and the FIFO is non-empty, regardless of any concurrent write.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (wr_en & ~wr_acc) | (overflow & ~clr_err);
      underflow <= (rd_en & empty)   | (underflow & ~clr_err);
    end
  end

  // FWFT shows the head whenever data is present; standard mode loads dout
  // only on an accepted read.
  assign mem_rd_en = (FWFT != 0) ? ~empty : rd_acc;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .REG_READ   (FWFT == 0)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (din),
    .rd_en   (mem_rd_en),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (dout)
  );

endmodule

// File: tb/tb_flex_fifo.sv
// Self-checking bench for flex_fifo: standard and FWFT instances share stimulus
// and are compared against a queue-based reference model.
module tb_flex_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] din = '0;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [3:0]    s_count, f_count;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_dout = '0;
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;

    typedef struct {
        logic          wr;
        logic          rd;
        logic [DW-1:0] din;
        logic          clr;
        int            e_cnt;
        logic          e_full;
        logic          e_empty;
        logic          e_af;
        logic          e_ae;
        logic [DW-1:0] e_dout;
        logic [DW-1:0] e_fdout;
        logic          e_ovf;
        logic          e_unf;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    flex_fifo #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(0),
        .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
    ) dut_std (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .clr_err(clr_err), .dout(s_dout), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf)
    );

    flex_fifo #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(1),
        .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
    ) dut_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .clr_err(clr_err), .dout(f_dout), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_step(input logic w, input logic r, input logic [DW-1:0] d, input logic c);
        bit rd_ok;
        bit wr_ok;
        rd_ok = r && (exp_q.size() != 0);
        wr_ok = w && ((exp_q.size() < DEPTH) || rd_ok);
        m_ovf = (w && !wr_ok) || (m_ovf && !c);
        m_unf = (r && (exp_q.size() == 0)) || (m_unf && !c);
        if (rd_ok) m_dout = exp_q.pop_front();
        if (wr_ok) exp_q.push_back(d);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    // Apply one cycle of stimulus; return at the following negedge.
    task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d, input logic c);
        wr_en   = w;
        rd_en   = r;
        din     = d;
        clr_err = c;
        @(posedge clk);
        model_step(w, r, d, c);
        @(negedge clk);
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic check_model(input string tag);
        int            n;
        logic [DW-1:0] head;
        n    = exp_q.size();
        head = (n != 0) ? exp_q[0] : '0;
        chk({tag, "_cnt"},    32'(s_count), n);
        chk({tag, "_fcnt"},   32'(f_count), n);
        chk({tag, "_full"},   32'(s_full),  32'(n == DEPTH));
        chk({tag, "_empty"},  32'(s_empty), 32'(n == 0));
        chk({tag, "_fempty"}, 32'(f_empty), 32'(n == 0));
        chk({tag, "_af"},     32'(s_af),    32'(n >= AF));
        chk({tag, "_ae"},     32'(s_ae),    32'(n <= AE));
        chk({tag, "_dout"},   32'(s_dout),  32'(m_dout));
        chk({tag, "_fdout"},  32'(f_dout),  32'(head));
        chk({tag, "_ovf"},    32'(s_ovf),   32'(m_ovf));
        chk({tag, "_unf"},    32'(s_unf),   32'(m_unf));
        chk({tag, "_fovf"},   32'(f_ovf),   32'(m_ovf));
        chk({tag, "_funf"},   32'(f_unf),   32'(m_unf));
    endtask

    function automatic vec_t mk(input logic w, r, input logic [DW-1:0] d, input logic c,
                                input int cnt, input logic fu, em, af, ae,
                                input logic [DW-1:0] dq, fq, input logic ov, un);
        vec_t v;
        v.wr = w; v.rd = r; v.din = d; v.clr = c;
        v.e_cnt = cnt; v.e_full = fu; v.e_empty = em; v.e_af = af; v.e_ae = ae;
        v.e_dout = dq; v.e_fdout = fq; v.e_ovf = ov; v.e_unf = un;
        return v;
    endfunction

    initial begin
        // fill 0x01..0x08
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(1, 0, 8'(i), 0, i, i == 8, 0, i >= 6, i <= 2, 8'h00, 8'h01, 0, 0));
        vecs.push_back(mk(1, 0, 8'hAA, 0, 8, 1, 0, 1, 0, 8'h00, 8'h01, 1, 0)); // overflow
        vecs.push_back(mk(0, 0, 8'h00, 1, 8, 1, 0, 1, 0, 8'h00, 8'h01, 0, 0)); // clear
        vecs.push_back(mk(1, 1, 8'h09, 0, 8, 1, 0, 1, 0, 8'h01, 8'h02, 0, 0)); // rd+wr at full
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(0, 1, 8'h00, 0, 7 - k, 0, k == 7, k <= 1, k >= 5,
                              8'(2 + k), (k == 7) ? 8'h00 : 8'(3 + k), 0, 0));
        vecs.push_back(mk(1, 1, 8'h33, 0, 1, 0, 0, 0, 1, 8'h09, 8'h33, 0, 1)); // rd+wr at empty
        vecs.push_back(mk(0, 1, 8'h00, 0, 0, 0, 1, 0, 1, 8'h33, 8'h00, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 0, 1, 8'h33, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 1, 0, 0, 1, 0, 1, 8'h33, 8'h00, 0, 1)); // set beats clear
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 0, 1, 8'h33, 8'h00, 0, 0));

        // reset state
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check_model("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // directed table
        for (int i = 0; i < vecs.size(); i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            cycle(vecs[i].wr, vecs[i].rd, vecs[i].din, vecs[i].clr);
            chk({t, "_cnt"},   32'(s_count), vecs[i].e_cnt);
            chk({t, "_full"},  32'(s_full),  32'(vecs[i].e_full));
            chk({t, "_empty"}, 32'(s_empty), 32'(vecs[i].e_empty));
            chk({t, "_af"},    32'(s_af),    32'(vecs[i].e_af));
            chk({t, "_ae"},    32'(s_ae),    32'(vecs[i].e_ae));
            chk({t, "_dout"},  32'(s_dout),  32'(vecs[i].e_dout));
            chk({t, "_fdout"}, 32'(f_dout),  32'(vecs[i].e_fdout));
            chk({t, "_ovf"},   32'(s_ovf),   32'(vecs[i].e_ovf));
            chk({t, "_unf"},   32'(s_unf),   32'(vecs[i].e_unf));
        end

        // wrap-around: interleaved write/read pairs
        for (int i = 0; i < 40; i++) begin
            cycle(1, 0, 8'($urandom_range(0, 255)), 0);
            check_model("wrap_w");
            cycle(0, 1, 8'h00, 0);
            check_model("wrap_r");
        end

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
                  8'($urandom_range(0, 255)), $urandom_range(0, 99) < 5);
            check_model("rand");
        end

        // drain, clear errors, then build count=5 with a non-zero dout
        for (int i = 0; i < DEPTH + 1 && exp_q.size() != 0; i++)
            cycle(0, 1, 8'h00, 0);
        cycle(0, 0, 8'h00, 1);
        for (int i = 0; i < 6; i++)
            cycle(1, 0, 8'(8'h10 + i), 0);
        cycle(0, 1, 8'h00, 0);
        check_model("pre_rst");

        // asynchronous reset between edges, checked before any clock edge
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_model("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // FWFT single write then pop, also confirms operation resumes
        cycle(1, 0, 8'h5C, 0);
        check_model("fwft_wr");
        chk("fwft_head", 32'(f_dout), 32'h5C);
        cycle(0, 1, 8'h00, 0);
        check_model("fwft_pop");
        chk("fwft_empty", 32'(f_empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
